// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the divider scheduler.
// Optional feature macro used by this block: DIV_SCHED_TIMEOUT_EN (watchdog on the divider).
package div_sched_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Round-robin pointer advance: the slot after the one just served, wrapping at n.
    function automatic int next_id(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/div_sched_if.sv
// Bundle of the requester, divider and response handshakes of the scheduler.
// "slave" is the scheduler's view; "master" is the view of the surrounding logic
// (clients, divider datapath and response consumer).
interface div_sched_if #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;

    logic           dv_start;
    logic [W-1:0]   dv_a;
    logic [W-1:0]   dv_b;
    logic           dv_done;
    logic [W-1:0]   dv_q;
    logic [W-1:0]   dv_r;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_q;
    logic [W-1:0]   rsp_r;
    logic           rsp_dz;
    logic           rsp_err;

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready,
        output dv_start, dv_a, dv_b,
        input  dv_done, dv_q, dv_r,
        output rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready,
        input  dv_start, dv_a, dv_b,
        output dv_done, dv_q, dv_r,
        input  rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/div_sched_rr_arb.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr_i, searching cyclically. Holds no state; the pointer lives in the caller.
module div_sched_rr_arb #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o
);

    // Walk the requests starting from the pointer; the first hit wins.
    always_comb begin
        logic           found;
        int             idx;
        logic [IDW-1:0] idx_l;
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        idx_l    = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_l = IDW'(idx);
            if (!found && req_i[idx_l]) begin
                found        = 1'b1;
                gnt_o[idx_l] = 1'b1;
                gnt_id_o     = idx_l;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider among N requesters.
// Divide-by-zero jobs are answered locally without starting the divider.
// Optional macro DIV_SCHED_TIMEOUT_EN adds a watchdog on the divider
// (TO_CYC cycles); without it WAIT waits forever and rsp_err is tied low.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int W      = DEF_W,
    parameter int IDW    = $clog2(N),
    parameter int TO_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    div_sched_if.slave bus
);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   r_q, r_d;
    logic           dz_q, dz_d;

    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   req_ready_c;
    logic           dv_start_c;

    logic [W-1:0]   a_arr [N];
    logic [W-1:0]   b_arr [N];

`ifdef DIV_SCHED_TIMEOUT_EN
    localparam int CNTW = $clog2(TO_CYC + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Unpack the flat operand buses so the granted slot can be selected by id.
    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_unpack
        assign a_arr[gi] = bus.req_a[gi*W +: W];
        assign b_arr[gi] = bus.req_b[gi*W +: W];
    end

    div_sched_rr_arb #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req_i    (bus.req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    // State, operand and result registers; reset drops any in-flight job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            q_q      <= q_d;
            r_q      <= r_d;
            dz_q     <= dz_d;
        end
    end

`ifdef DIV_SCHED_TIMEOUT_EN
    // Watchdog counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    // Next-state and output decode for IDLE -> (LAUNCH -> WAIT ->) RESP -> IDLE.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        q_d         = q_q;
        r_d         = r_q;
        dz_d        = dz_q;
        req_ready_c = '0;
        dv_start_c  = 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                req_ready_c = gnt;
                if (|(bus.req_valid & gnt)) begin
                    a_d      = a_arr[gnt_id];
                    b_d      = b_arr[gnt_id];
                    id_d     = gnt_id;
                    rr_ptr_d = IDW'(next_id(int'(gnt_id), N));
                    if (b_arr[gnt_id] == '0) begin
                        // Zero divisor: answer immediately, divider stays idle.
                        q_d     = '1;
                        r_d     = a_arr[gnt_id];
                        dz_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                dv_start_c = 1'b1;
                state_d    = WAIT;
`ifdef DIV_SCHED_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            WAIT: begin
                if (bus.dv_done) begin
                    q_d     = bus.dv_q;
                    r_d     = bus.dv_r;
                    dz_d    = 1'b0;
                    state_d = RESP;
`ifdef DIV_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNTW'(TO_CYC - 1)) begin
                    // Divider silent for TO_CYC cycles: report an error result.
                    q_d     = '0;
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    dz_d    = 1'b0;
                    state_d = IDLE;
`ifdef DIV_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.dv_start  = dv_start_c;
    assign bus.dv_a      = a_q;
    assign bus.dv_b      = b_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_q     = q_q;
    assign bus.rsp_r     = r_q;
    assign bus.rsp_dz    = dz_q;
`ifdef DIV_SCHED_TIMEOUT_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule
